match_controller: RTL and testbench

- Parametrised successor to the top-level round/reset logic, which today is a fixed 2-player "winner" code plus a 40-tick hold-to-reset timer.
- Sequences a full match: intro countdown, timed fight rounds, KO/time-out judging, best-of-N round tally, match end and hold-to-restart.
- Sits between HealthManagement (health inputs) and the PhysicsEngine, HealthManagement and menu blocks (round_reset, play_enable, state outputs).
- Runs on the 100 MHz clk and advances only on a 1-cycle game_tick strobe (20 Hz).

---
 rtl/match_pkg.sv | 35 +++
 rtl/match_if.sv | 39 +++
 rtl/match_judge.sv | 41 ++++
 rtl/match_controller.sv | 160 ++++++++++++++++
 tb/tb_match_controller.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/match_pkg.sv
// Shared definitions for the match sequencer.
// Contents:
//   - state encoding (IDLE=0, INTRO=1, FIGHT=2, ROUND_END=3, MATCH_END=4) and the FSM enum
//   - default timing constants (ticks at the 20 Hz game_tick rate)
//   - winner_w(): width of a winner code (0 = none/draw, k = player k-1)
package match_pkg;

    localparam logic [2:0] STATE_IDLE      = 3'd0;
    localparam logic [2:0] STATE_INTRO     = 3'd1;
    localparam logic [2:0] STATE_FIGHT     = 3'd2;
    localparam logic [2:0] STATE_ROUND_END = 3'd3;
    localparam logic [2:0] STATE_MATCH_END = 3'd4;

    typedef enum logic [2:0] {
        StIdle     = STATE_IDLE,
        StIntro    = STATE_INTRO,
        StFight    = STATE_FIGHT,
        StRoundEnd = STATE_ROUND_END,
        StMatchEnd = STATE_MATCH_END
    } match_state_e;

    localparam int unsigned DEF_NUM_PLAYERS   = 2;
    localparam int unsigned DEF_HP_W          = 9;
    localparam int unsigned DEF_ROUNDS_TO_WIN = 2;
    localparam int unsigned DEF_INTRO_TICKS   = 60;
    localparam int unsigned DEF_ROUND_TICKS   = 1200;
    localparam int unsigned DEF_END_TICKS     = 40;
    localparam int unsigned DEF_HOLD_TICKS    = 40;

    // Winner codes need one extra value for "none/draw".
    function automatic int unsigned winner_w(input int unsigned n_players);
        return $clog2(n_players + 1);
    endfunction

endpackage

// File: rtl/match_if.sv
// Bundle of the match controller's game-side signals.
// master: drives game_tick, health, start_btn, reset_req; observes the status outputs.
// slave : the match controller (consumes the inputs, drives state, play_enable, round_reset,
//         time_left, round_winner, match_winner, round_wins).
interface match_if
    import match_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = DEF_NUM_PLAYERS,
    parameter int unsigned HP_W        = DEF_HP_W,
    parameter int unsigned ROUND_TICKS = DEF_ROUND_TICKS
);
    localparam int unsigned WW = winner_w(NUM_PLAYERS);
    localparam int unsigned TW = $clog2(ROUND_TICKS + 1);

    logic                        game_tick;
    logic [NUM_PLAYERS*HP_W-1:0] health;
    logic                        start_btn;
    logic                        reset_req;
    logic [2:0]                  state;
    logic                        play_enable;
    logic                        round_reset;
    logic [TW-1:0]               time_left;
    logic [WW-1:0]               round_winner;
    logic [WW-1:0]               match_winner;
    logic [NUM_PLAYERS*2-1:0]    round_wins;

    modport master (
        output game_tick, health, start_btn, reset_req,
        input  state, play_enable, round_reset, time_left, round_winner, match_winner,
               round_wins
    );

    modport slave (
        input  game_tick, health, start_btn, reset_req,
        output state, play_enable, round_reset, time_left, round_winner, match_winner,
               round_wins
    );

endinterface

// File: rtl/match_judge.sv
// Combinational round judge.
// Ports:
//   health : packed per-player health, player 0 in the LSBs
//   winner : k = player k-1 holds the unique strictly highest non-zero health;
//            0 when that maximum is shared or every player is at zero
module match_judge
    import match_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = DEF_NUM_PLAYERS,
    parameter int unsigned HP_W        = DEF_HP_W
) (
    input  logic [NUM_PLAYERS*HP_W-1:0]      health,
    output logic [winner_w(NUM_PLAYERS)-1:0] winner
);
    localparam int unsigned WW = winner_w(NUM_PLAYERS);

    logic [HP_W-1:0] best;
    logic [HP_W-1:0] h;
    logic [WW-1:0]   best_id;
    logic [WW-1:0]   n_best;

    always_comb begin
        best    = '0;
        best_id = '0;
        n_best  = '0;
        h       = '0;
        // Starting from best=0 means zero-health players can never become the leader.
        for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
            h = health[i*HP_W +: HP_W];
            if (h > best) begin
                best    = h;
                best_id = WW'(i + 1);
                n_best  = WW'(1);
            end else if (h == best && h != '0) begin
                n_best = n_best + 1'b1;
            end
        end
        winner = (best != '0 && n_best == WW'(1)) ? best_id : '0;
    end

endmodule

// File: rtl/match_controller.sv
// Match sequencer: intro countdown, timed fight rounds, KO/time-out judging, best-of-N tally,
// match end and hold-to-restart. All progress is gated by the 1-cycle game_tick strobe, except
// round_reset which is a single-clk pulse on the edge that enters INTRO.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : match_if.slave (game_tick, health, start_btn, reset_req in;
//           state, play_enable, round_reset, time_left, round_winner, match_winner,
//           round_wins out)
module match_controller
    import match_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS   = DEF_NUM_PLAYERS,
    parameter int unsigned HP_W          = DEF_HP_W,
    parameter int unsigned ROUNDS_TO_WIN = DEF_ROUNDS_TO_WIN,
    parameter int unsigned INTRO_TICKS   = DEF_INTRO_TICKS,
    parameter int unsigned ROUND_TICKS   = DEF_ROUND_TICKS,
    parameter int unsigned END_TICKS     = DEF_END_TICKS,
    parameter int unsigned HOLD_TICKS    = DEF_HOLD_TICKS
) (
    input  logic    clk,
    input  logic    reset,
    match_if.slave  bus
);
    localparam int unsigned WW     = winner_w(NUM_PLAYERS);
    localparam int unsigned TW     = $clog2(ROUND_TICKS + 1);
    localparam int unsigned PH_MAX = (INTRO_TICKS > END_TICKS) ? INTRO_TICKS : END_TICKS;
    localparam int unsigned CW     = $clog2(PH_MAX + 1);
    localparam int unsigned HW     = $clog2(HOLD_TICKS + 1);

    match_state_e             state_q;
    logic [CW-1:0]            phase_cnt_q;
    logic [HW-1:0]            hold_cnt_q;
    logic [TW-1:0]            time_left_q;
    logic [WW-1:0]            round_winner_q;
    logic [WW-1:0]            match_winner_q;
    logic [NUM_PLAYERS*2-1:0] round_wins_q;
    logic                     round_reset_q;

    logic [WW-1:0]            judge_winner;
    logic                     any_ko;
    logic [NUM_PLAYERS*2-1:0] wins_credited;
    logic [WW-1:0]            match_leader;
    logic                     hold_fire;
    logic                     new_match;
    logic                     next_round;
    logic                     enter_intro;

    match_judge #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .HP_W        (HP_W)
    ) u_judge (
        .health (bus.health),
        .winner (judge_winner)
    );

    always_comb begin
        any_ko        = 1'b0;
        wins_credited = round_wins_q;
        match_leader  = '0;
        for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
            if (bus.health[i*HP_W +: HP_W] == '0) begin
                any_ko = 1'b1;
            end
            // Per-player win counters saturate at 3.
            if (judge_winner == WW'(i + 1) && round_wins_q[2*i +: 2] != 2'd3) begin
                wins_credited[2*i +: 2] = round_wins_q[2*i +: 2] + 2'd1;
            end
            if (round_wins_q[2*i +: 2] >= 2'(ROUNDS_TO_WIN)) begin
                match_leader = WW'(i + 1);
            end
        end
    end

    always_comb begin
        // The hold counter keeps counting through the firing tick, so it sits at HOLD_TICKS
        // afterwards and cannot re-fire until reset_req is released.
        hold_fire   = bus.game_tick && bus.reset_req && (hold_cnt_q == HW'(HOLD_TICKS - 1));
        new_match   = hold_fire || (bus.game_tick && state_q == StIdle && bus.start_btn);
        next_round  = bus.game_tick && !hold_fire && state_q == StRoundEnd &&
                      phase_cnt_q == CW'(END_TICKS - 1) && match_leader == '0;
        enter_intro = new_match || next_round;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            phase_cnt_q    <= '0;
            hold_cnt_q     <= '0;
            time_left_q    <= TW'(ROUND_TICKS);
            round_winner_q <= '0;
            match_winner_q <= '0;
            round_wins_q   <= '0;
            round_reset_q  <= 1'b0;
        end else begin
            round_reset_q <= 1'b0;
            if (bus.game_tick) begin
                if (!bus.reset_req) begin
                    hold_cnt_q <= '0;
                end else if (hold_cnt_q != HW'(HOLD_TICKS)) begin
                    hold_cnt_q <= hold_cnt_q + 1'b1;
                end

                if (enter_intro) begin
                    state_q        <= StIntro;
                    phase_cnt_q    <= '0;
                    time_left_q    <= TW'(ROUND_TICKS);
                    round_winner_q <= '0;
                    // Guards against back-to-back pulses when ticks arrive on adjacent cycles.
                    round_reset_q  <= ~round_reset_q;
                    if (new_match) begin
                        round_wins_q   <= '0;
                        match_winner_q <= '0;
                    end
                end else begin
                    case (state_q)
                        StIntro: begin
                            if (phase_cnt_q == CW'(INTRO_TICKS - 1)) begin
                                state_q     <= StFight;
                                phase_cnt_q <= '0;
                                time_left_q <= TW'(ROUND_TICKS);
                            end else begin
                                phase_cnt_q <= phase_cnt_q + 1'b1;
                            end
                        end
                        StFight: begin
                            time_left_q <= time_left_q - 1'b1;
                            if (any_ko || time_left_q == TW'(1)) begin
                                state_q        <= StRoundEnd;
                                phase_cnt_q    <= '0;
                                round_winner_q <= judge_winner;
                                round_wins_q   <= wins_credited;
                            end
                        end
                        StRoundEnd: begin
                            // Reaching the last tick here without enter_intro means a leader exists.
                            if (phase_cnt_q == CW'(END_TICKS - 1)) begin
                                state_q        <= StMatchEnd;
                                match_winner_q <= match_leader;
                            end else begin
                                phase_cnt_q <= phase_cnt_q + 1'b1;
                            end
                        end
                        StIdle, StMatchEnd: ;
                        default: state_q <= StIdle;
                    endcase
                end
            end
        end
    end

    assign bus.state        = state_q;
    assign bus.play_enable  = (state_q == StFight);
    assign bus.round_reset  = round_reset_q;
    assign bus.time_left    = time_left_q;
    assign bus.round_winner = round_winner_q;
    assign bus.match_winner = match_winner_q;
    assign bus.round_wins   = round_wins_q;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: the stimulus thread pushes the expected status record
// for every state change it provokes; monitor threads pop and compare on each state change.
// DUT a: defaults (2 players). DUT b: 4 players with short timings.
module tb_match_controller;

    typedef struct packed {
        logic [2:0]  st;
        logic [2:0]  rwin;
        logic [2:0]  mwin;
        logic [7:0]  wins;
        logic [10:0] tl;
        logic        pe;
    } ev_t;

    logic clk = 1'b0;
    logic reset_a = 1'b0;
    logic reset_b = 1'b0;
    always #5 clk = ~clk;

    match_if #(.NUM_PLAYERS(2), .HP_W(9), .ROUND_TICKS(1200)) bus_a ();
    match_if #(.NUM_PLAYERS(4), .HP_W(9), .ROUND_TICKS(8))    bus_b ();

    match_controller #(
        .NUM_PLAYERS(2), .HP_W(9), .ROUNDS_TO_WIN(2), .INTRO_TICKS(60),
        .ROUND_TICKS(1200), .END_TICKS(40), .HOLD_TICKS(40)
    ) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a)
    );

    match_controller #(
        .NUM_PLAYERS(4), .HP_W(9), .ROUNDS_TO_WIN(2), .INTRO_TICKS(4),
        .ROUND_TICKS(8), .END_TICKS(3), .HOLD_TICKS(5)
    ) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    ev_t q_a[$];
    ev_t q_b[$];
    int unsigned rr_a = 0;
    int unsigned rr_b = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic ev_t mk(input int st, input int rwin, input int mwin, input int wins,
                               input int tl);
        ev_t e;
        e.st   = 3'(st);
        e.rwin = 3'(rwin);
        e.mwin = 3'(mwin);
        e.wins = 8'(wins);
        e.tl   = 11'(tl);
        e.pe   = (st == 2);
        return e;
    endfunction

    task automatic tick_a(input int n);
        repeat (n) begin
            @(negedge clk); bus_a.game_tick = 1'b1;
            @(negedge clk); bus_a.game_tick = 1'b0;
        end
    endtask

    task automatic tick_b(input int n);
        repeat (n) begin
            @(negedge clk); bus_b.game_tick = 1'b1;
            @(negedge clk); bus_b.game_tick = 1'b0;
        end
    endtask

    task automatic reset_check_a(input string tag);
        chk({tag, "_state"}, 64'(bus_a.state), 64'd0);
        chk({tag, "_time_left"}, 64'(bus_a.time_left), 64'd1200);
        chk({tag, "_round_wins"}, 64'(bus_a.round_wins), 64'd0);
        chk({tag, "_round_winner"}, 64'(bus_a.round_winner), 64'd0);
        chk({tag, "_match_winner"}, 64'(bus_a.match_winner), 64'd0);
        chk({tag, "_play_enable"}, 64'(bus_a.play_enable), 64'd0);
        chk({tag, "_round_reset"}, 64'(bus_a.round_reset), 64'd0);
    endtask

    // Monitor for DUT a.
    initial begin
        logic [2:0] prev;
        logic       rr_prev;
        ev_t        cur;
        ev_t        e;
        prev    = 3'd0;
        rr_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_a) begin
                prev    = bus_a.state;
                rr_prev = 1'b0;
            end else begin
                cur.st   = bus_a.state;
                cur.rwin = 3'(bus_a.round_winner);
                cur.mwin = 3'(bus_a.match_winner);
                cur.wins = 8'(bus_a.round_wins);
                cur.tl   = 11'(bus_a.time_left);
                cur.pe   = bus_a.play_enable;
                if (cur.st != prev) begin
                    chk("a_transition_expected", 64'(q_a.size() != 0), 64'd1);
                    if (q_a.size() != 0) begin
                        e = q_a.pop_front();
                        chk("a_transition", 64'(cur), 64'(e));
                    end
                end
                if (bus_a.round_reset) begin
                    rr_a++;
                    chk("a_round_reset_not_consecutive", 64'(rr_prev), 64'd0);
                    chk("a_round_reset_enters_intro", 64'(cur.st != prev && cur.st == 3'd1), 64'd1);
                end
                prev    = cur.st;
                rr_prev = bus_a.round_reset;
            end
        end
    end

    // Monitor for DUT b.
    initial begin
        logic [2:0] prev;
        logic       rr_prev;
        ev_t        cur;
        ev_t        e;
        prev    = 3'd0;
        rr_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_b) begin
                prev    = bus_b.state;
                rr_prev = 1'b0;
            end else begin
                cur.st   = bus_b.state;
                cur.rwin = 3'(bus_b.round_winner);
                cur.mwin = 3'(bus_b.match_winner);
                cur.wins = 8'(bus_b.round_wins);
                cur.tl   = 11'(bus_b.time_left);
                cur.pe   = bus_b.play_enable;
                if (cur.st != prev) begin
                    chk("b_transition_expected", 64'(q_b.size() != 0), 64'd1);
                    if (q_b.size() != 0) begin
                        e = q_b.pop_front();
                        chk("b_transition", 64'(cur), 64'(e));
                    end
                end
                if (bus_b.round_reset) begin
                    rr_b++;
                    chk("b_round_reset_not_consecutive", 64'(rr_prev), 64'd0);
                end
                prev    = cur.st;
                rr_prev = bus_b.round_reset;
            end
        end
    end

    initial begin
        bus_a.game_tick = 1'b0;
        bus_a.health    = '0;
        bus_a.start_btn = 1'b0;
        bus_a.reset_req = 1'b0;
        bus_b.game_tick = 1'b0;
        bus_b.health    = '0;
        bus_b.start_btn = 1'b0;
        bus_b.reset_req = 1'b0;
        repeat (3) @(negedge clk);
        reset_check_a("a_reset");
        @(posedge clk); #1;
        reset_a = 1'b1;
        reset_b = 1'b1;

        // ---- DUT a: IDLE ignores ticks without start, then start a match.
        tick_a(3);
        bus_a.start_btn = 1'b1;
        q_a.push_back(mk(1, 0, 0, 0, 1200));
        tick_a(1);
        bus_a.start_btn = 1'b0;
        // Health changes during INTRO are ignored.
        bus_a.health = {9'd0, 9'd150};
        tick_a(59);
        bus_a.health = {9'd120, 9'd150};
        q_a.push_back(mk(2, 0, 0, 0, 1200));
        tick_a(1);
        chk("a_one_round_reset_at_start", 64'(rr_a), 64'd1);

        // KO on fight tick 100: P1 to 0, P0 at 150.
        tick_a(99);
        chk("a_time_left_after_99", 64'(bus_a.time_left), 64'd1101);
        chk("a_play_enable_fight", 64'(bus_a.play_enable), 64'd1);
        bus_a.health = {9'd0, 9'd150};
        q_a.push_back(mk(3, 1, 0, 1, 1100));
        tick_a(1);
        tick_a(39);
        q_a.push_back(mk(1, 0, 0, 1, 1200));
        tick_a(1);
        chk("a_round_reset_after_round_end", 64'(rr_a), 64'd2);

        // Round 2: short hold is ignored, full hold mid-fight restarts.
        bus_a.health = {9'd120, 9'd150};
        tick_a(59);
        q_a.push_back(mk(2, 0, 0, 1, 1200));
        tick_a(1);
        bus_a.reset_req = 1'b1;
        tick_a(39);
        bus_a.reset_req = 1'b0;
        tick_a(1);
        chk("a_hold_39_no_restart", 64'(bus_a.state), 64'd2);
        chk("a_time_left_after_40", 64'(bus_a.time_left), 64'd1160);
        bus_a.reset_req = 1'b1;
        q_a.push_back(mk(1, 0, 0, 0, 1200));
        tick_a(40);
        chk("a_restart_single_pulse", 64'(rr_a), 64'd3);
        tick_a(59);
        q_a.push_back(mk(2, 0, 0, 0, 1200));
        tick_a(1);
        tick_a(20);
        chk("a_held_no_second_pulse", 64'(rr_a), 64'd3);
        bus_a.reset_req = 1'b0;

        // Time-out with equal health: draw.
        bus_a.health = {9'd80, 9'd80};
        tick_a(1179);
        chk("a_time_left_last", 64'(bus_a.time_left), 64'd1);
        q_a.push_back(mk(3, 0, 0, 0, 0));
        tick_a(1);
        tick_a(39);
        q_a.push_back(mk(1, 0, 0, 0, 1200));
        tick_a(1);

        // P0 wins two rounds.
        bus_a.health = {9'd0, 9'd150};
        tick_a(59);
        q_a.push_back(mk(2, 0, 0, 0, 1200));
        tick_a(1);
        q_a.push_back(mk(3, 1, 0, 1, 1199));
        tick_a(1);
        tick_a(39);
        q_a.push_back(mk(1, 0, 0, 1, 1200));
        tick_a(1);
        bus_a.health = {9'd0, 9'd5};
        tick_a(59);
        q_a.push_back(mk(2, 0, 0, 1, 1200));
        tick_a(1);
        q_a.push_back(mk(3, 1, 0, 2, 1199));
        tick_a(1);
        tick_a(39);
        q_a.push_back(mk(4, 1, 1, 2, 1199));
        tick_a(1);
        chk("a_round_resets_before_match_end", 64'(rr_a), 64'd5);
        bus_a.start_btn = 1'b1;
        tick_a(5);
        bus_a.start_btn = 1'b0;
        chk("a_match_end_ignores_start", 64'(bus_a.state), 64'd4);
        chk("a_match_winner", 64'(bus_a.match_winner), 64'd1);

        // Restart from MATCH_END after a released short hold.
        bus_a.reset_req = 1'b1;
        tick_a(39);
        bus_a.reset_req = 1'b0;
        tick_a(1);
        chk("a_match_end_hold_39", 64'(bus_a.state), 64'd4);
        bus_a.reset_req = 1'b1;
        q_a.push_back(mk(1, 0, 0, 0, 1200));
        tick_a(40);
        bus_a.reset_req = 1'b0;
        chk("a_restart_from_match_end", 64'(rr_a), 64'd6);
        tick_a(59);
        q_a.push_back(mk(2, 0, 0, 0, 1200));
        tick_a(1);
        q_a.push_back(mk(3, 1, 0, 1, 1199));
        tick_a(1);
        tick_a(10);

        // Async reset mid-ROUND_END, checked before any further clock edge.
        @(posedge clk); #2;
        reset_a = 1'b0;
        #1;
        reset_check_a("a_async_reset");
        @(posedge clk); #1;
        reset_a = 1'b1;
        chk("a_queue_drained", 64'(q_a.size()), 64'd0);

        // ---- DUT b: four players.
        bus_b.health    = {9'd10, 9'd40, 9'd0, 9'd20};
        bus_b.start_btn = 1'b1;
        q_b.push_back(mk(1, 0, 0, 0, 8));
        tick_b(1);
        bus_b.start_btn = 1'b0;
        tick_b(3);
        q_b.push_back(mk(2, 0, 0, 0, 8));
        tick_b(1);
        // KO: player 2 leads uniquely with 40.
        q_b.push_back(mk(3, 3, 0, 8'h10, 7));
        tick_b(1);
        tick_b(2);
        q_b.push_back(mk(1, 0, 0, 8'h10, 8));
        tick_b(1);
        bus_b.health = {9'd10, 9'd50, 9'd50, 9'd30};
        tick_b(3);
        q_b.push_back(mk(2, 0, 0, 8'h10, 8));
        tick_b(1);
        tick_b(7);
        chk("b_time_left_last", 64'(bus_b.time_left), 64'd1);
        // Time-out and KO on the same tick, 0/50/50/10: tie at the top is a draw.
        bus_b.health = {9'd10, 9'd50, 9'd50, 9'd0};
        q_b.push_back(mk(3, 0, 0, 8'h10, 0));
        tick_b(1);
        tick_b(2);
        q_b.push_back(mk(1, 0, 0, 8'h10, 8));
        tick_b(1);
        bus_b.health = {9'd10, 9'd40, 9'd0, 9'd20};
        tick_b(3);
        q_b.push_back(mk(2, 0, 0, 8'h10, 8));
        tick_b(1);
        q_b.push_back(mk(3, 3, 0, 8'h20, 7));
        tick_b(1);
        tick_b(2);
        q_b.push_back(mk(4, 3, 3, 8'h20, 7));
        tick_b(1);
        tick_b(2);
        chk("b_round_reset_count", 64'(rr_b), 64'd3);
        chk("b_queue_drained", 64'(q_b.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
